prog_loader: RTL and testbench

Byte-stream program loader that sits between a host link and the CPU's instruction RAM. It holds the CPU in reset, accepts a framed byte stream (sync, start address, word count, 16-bit words, checksum) and writes each assembled word into RAM through the RAM write port. On a valid checksum it releases the CPU; on a bad checksum it keeps the CPU held and flags an error. This replaces backdoor RAM preloading with a real, synthesizable load path.

---
 rtl/prog_loader.sv | 167 ++++++++++++++++
 tb/tb_prog_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Framed byte-stream loader: holds the CPU in reset, writes 16-bit words into
// instruction RAM, and releases the CPU only when the frame checksum matches.
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_SYNC,
        S_ADDR,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          acc_q, acc_d;
    logic [7:0]          hi_q, hi_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;

    // in_ready is the only output decoded straight from state.
    assign in_ready = (state_q == S_SYNC) || (state_q == S_ADDR) || (state_q == S_COUNT) ||
                      (state_q == S_HI)   || (state_q == S_LO)   || (state_q == S_CHK);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_SYNC: begin
                if (xfer && (in_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    ptr_d   = ADDR_W'(in_data);
                    acc_d   = in_data;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    cnt_d   = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = (in_data != 8'd0) ? S_HI : S_CHK;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    acc_d   = acc_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    acc_d   = acc_q ^ in_data;
                    wdata_d = {hi_q, in_data};
                    addr_d  = ptr_q;
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // cnt_q still holds the count including the word just written.
                ptr_d   = ptr_q + ADDR_W'(1);
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q != 8'd1) ? S_HI : S_CHK;
            end
            S_CHK: begin
                if (xfer) begin
                    if (in_data == acc_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_SYNC;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_SYNC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign error     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are parsed by a byte-list model into expected
// RAM writes and a pass/fail verdict, and a negedge monitor checks every write.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        restart;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          gapMax = 0;
    int          writeCount = 0;
    int          wcBefore;
    bit          prevWe = 1'b0;
    bit          expGood;
    logic [7:0]  txBytes[$];
    wr_t         expWrites[$];
    logic [15:0] ramSeen[256];

    prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .restart   (restart),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: parse the frame bytes into the writes it implies and its verdict.
    task automatic planFrame();
        int         n;
        int         cnt;
        logic [7:0] x;
        logic [7:0] a;
        n   = txBytes.size();
        cnt = int'(txBytes[2]);
        x   = 8'h00;
        for (int i = 1; i < n - 1; i++) x ^= txBytes[i];
        for (int i = 0; i < cnt; i++) begin
            a = txBytes[1] + 8'(i);
            expWrites.push_back('{a, {txBytes[3 + 2 * i], txBytes[4 + 2 * i]}});
        end
        expGood = (x == txBytes[n - 1]);
    endtask

    task automatic buildRandom(input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        int         cnt;
        txBytes.delete();
        txBytes.push_back(8'hA5);
        b = 8'($urandom);
        txBytes.push_back(b);
        x = b;
        cnt = $urandom_range(0, 5);
        txBytes.push_back(8'(cnt));
        x ^= 8'(cnt);
        repeat (2 * cnt) begin
            b = 8'($urandom);
            txBytes.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        txBytes.push_back(x);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waitCnt = 0;
        repeat ($urandom_range(0, gapMax)) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL readyTimeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulseRestart(input bit checkRearm);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        if (checkRearm) begin
            checkOutput("rearmHold", cpu_hold, 1);
            checkOutput("rearmDone", done, 0);
            checkOutput("rearmError", error, 0);
            checkOutput("rearmReady", in_ready, 1);
        end
    endtask

    task automatic sendFrame(input int restartAt);
        planFrame();
        for (int i = 0; i < txBytes.size(); i++) begin
            if (i == restartAt) pulseRestart(1'b0);
            applyStimulus(txBytes[i]);
        end
        checkOutput("frameDone", done, expGood);
        checkOutput("frameError", error, !expGood);
        checkOutput("frameHold", cpu_hold, !expGood);
        checkOutput("frameReadyLow", in_ready, 0);
        checkOutput("pendingWrites", expWrites.size(), 0);
    endtask

    task automatic sendGarbage(input int n);
        logic [7:0] g;
        repeat (n) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            applyStimulus(g);
        end
    endtask

    // Every cycle: compare any write against the model's next expected write.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("holdVsDone", cpu_hold, !done);
            checkOutput("doneErrExcl", done & error, 0);
            if (ram_we) begin
                checkOutput("readyInWrite", in_ready, 0);
                checkOutput("weSingleCycle", prevWe, 0);
                if (expWrites.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
                end else begin
                    wr_t e;
                    e = expWrites.pop_front();
                    checkOutput("writeAddr", ram_addr, e.addr);
                    checkOutput("writeData", ram_wdata, e.data);
                end
                ramSeen[ram_addr] = ram_wdata;
                writeCount++;
            end
            prevWe = ram_we;
        end else begin
            prevWe = 1'b0;
        end
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        for (int i = 0; i < 256; i++) ramSeen[i] = 16'h0000;

        #12;
        checkOutput("rstReady", in_ready, 1);
        checkOutput("rstWe", ram_we, 0);
        checkOutput("rstAddr", ram_addr, 0);
        checkOutput("rstWdata", ram_wdata, 0);
        checkOutput("rstHold", cpu_hold, 1);
        checkOutput("rstDone", done, 0);
        checkOutput("rstError", error, 0);
        @(negedge clk);
        reset = 1'b1;

        // Abort mid-frame with the CPU still held and nothing written.
        txBytes = '{8'hA5, 8'h10, 8'h02, 8'h40, 8'h01, 8'h80, 8'h03, 8'hD0};
        planFrame();
        for (int i = 0; i < 4; i++) applyStimulus(txBytes[i]);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        expWrites.delete();
        checkOutput("midRstReady", in_ready, 1);
        checkOutput("midRstHold", cpu_hold, 1);
        checkOutput("midRstWe", ram_we, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstError", error, 0);
        @(negedge clk);
        reset = 1'b1;

        // Nominal load.
        wcBefore = writeCount;
        txBytes = '{8'hA5, 8'h10, 8'h02, 8'h40, 8'h01, 8'h80, 8'h03, 8'hD0};
        sendFrame(-1);
        checkOutput("nomRam10", ramSeen[8'h10], 16'h4001);
        checkOutput("nomRam11", ramSeen[8'h11], 16'h8003);
        checkOutput("nomWrites", writeCount - wcBefore, 2);
        checkOutput("nomDone", done, 1);
        pulseRestart(1'b1);

        // Bad checksum still writes both words.
        wcBefore = writeCount;
        txBytes = '{8'hA5, 8'h10, 8'h02, 8'h40, 8'h01, 8'h80, 8'h03, 8'hD1};
        sendFrame(-1);
        checkOutput("badError", error, 1);
        checkOutput("badHold", cpu_hold, 1);
        checkOutput("badWrites", writeCount - wcBefore, 2);
        pulseRestart(1'b1);

        // Garbage then empty frame.
        wcBefore = writeCount;
        applyStimulus(8'h00);
        applyStimulus(8'h7F);
        txBytes = '{8'hA5, 8'h20, 8'h00, 8'h20};
        sendFrame(-1);
        checkOutput("emptyDone", done, 1);
        checkOutput("emptyWrites", writeCount - wcBefore, 0);
        pulseRestart(1'b1);

        // Address wrap with random valid gaps.
        gapMax = 3;
        txBytes = '{8'hA5, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5};
        sendFrame(-1);
        checkOutput("wrapRamFF", ramSeen[8'hFF], 16'h1234);
        checkOutput("wrapRam00", ramSeen[8'h00], 16'h5678);
        checkOutput("wrapDone", done, 1);
        pulseRestart(1'b1);

        // Restart mid-frame must be ignored; after done it re-arms.
        gapMax = 0;
        txBytes = '{8'hA5, 8'h10, 8'h02, 8'h40, 8'h01, 8'h80, 8'h03, 8'hD0};
        sendFrame(5);
        pulseRestart(1'b1);
        buildRandom(1'b0);
        sendFrame(-1);
        pulseRestart(1'b1);

        for (int f = 0; f < 20; f++) begin
            gapMax = $urandom_range(0, 3);
            sendGarbage($urandom_range(0, 3));
            buildRandom($urandom_range(0, 3) == 0);
            sendFrame(($urandom_range(0, 1) == 1) ? $urandom_range(3, 6) : -1);
            pulseRestart(1'b1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
